snax_mac_stream_gen: RTL and testbench

- Parametrised, generation-2 TCDM streamer for MAC-class accelerators.
- Provides NUM_RD independent strided read channels that feed datapath streams, plus one strided write channel that drains a datapath result stream to TCDM.
- Adds over the previous streamer: configurable channel count, data width and FIFO depth; credit-based outstanding-request control; a start/busy/done job FSM; per-channel stride addressing.
- Sits between the accelerator controller/datapath and the TCDM interconnect.

---
 rtl/snax_mac_stream_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_snax_mac_stream_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_mac_stream_gen.sv
// -----------------------------------------------------------------------------
// snax_mac_stream_gen
// Generation-2 TCDM streamer for MAC-class accelerators. It has NUM_RD strided
// read channels, each feeding a first-word-fall-through response FIFO that
// drives a datapath stream. It also has one strided write channel that drains
// the datapath result stream to TCDM. A start/busy/done job FSM runs one job of
// len words per channel.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i, len_i           job start pulse (taken in IDLE only), words/channel
//   base_addr_i, stride_i    per-channel base and byte stride (slice NUM_RD = write)
//   busy_o, done_o           job in progress, one-cycle completion pulse
//   tcdm_*                   per-channel TCDM request/response (slice NUM_RD = write)
//   rd_valid_o/ready_i/data_o  read streams towards the datapath
//   wr_valid_i/ready_o/data_i  result stream from the datapath
// -----------------------------------------------------------------------------
module snax_mac_stream_gen #(
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [LEN_W-1:0]               len_i,
  input  logic [(NUM_RD+1)*ADDR_W-1:0]   base_addr_i,
  input  logic [(NUM_RD+1)*ADDR_W-1:0]   stride_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [NUM_RD:0]                tcdm_req_o,
  input  logic [NUM_RD:0]                tcdm_gnt_i,
  output logic [(NUM_RD+1)*ADDR_W-1:0]   tcdm_add_o,
  output logic [NUM_RD:0]                tcdm_wen_o,
  output logic [(NUM_RD+1)*DATA_W/8-1:0] tcdm_be_o,
  output logic [(NUM_RD+1)*DATA_W-1:0]   tcdm_data_o,
  input  logic [NUM_RD:0]                tcdm_r_valid_i,
  input  logic [(NUM_RD+1)*DATA_W-1:0]   tcdm_r_data_i,
  output logic [NUM_RD-1:0]              rd_valid_o,
  input  logic [NUM_RD-1:0]              rd_ready_i,
  output logic [NUM_RD*DATA_W-1:0]       rd_data_o,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [DATA_W-1:0]              wr_data_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              launch_s;
  logic              run_s;
  logic              all_done_s;
  logic [NUM_RD-1:0] rd_done_s;

  // The write channel response lane is never used.
  logic unused_s;
  assign unused_s = ^{tcdm_r_valid_i[NUM_RD], tcdm_r_data_i[NUM_RD*DATA_W +: DATA_W]};

  assign run_s  = (state_q == RUN);
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == FIN);
  assign tcdm_be_o = {((NUM_RD+1)*DATA_W/8){1'b1}};

  // Job FSM next state; launch_s marks the cycle a job's parameters are latched
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    launch_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          launch_s = 1'b1;
          len_d    = len_i;
          state_d  = (len_i == {LEN_W{1'b0}}) ? FIN : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (all_done_s) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job FSM state and latched length
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= {LEN_W{1'b0}};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // ---------------------------------------------------------------- read side
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [LEN_W-1:0]  issued_q, issued_d, popped_q, popped_d;
    logic [CNT_W-1:0]  outst_q, outst_d, cnt_q, cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              req_s, gnt_s, push_s, pop_s;

    // Credit: FIFO slots not yet filled or promised to an in-flight read.
    assign req_s  = run_s && (issued_q < len_q) && ((cnt_q + outst_q) < DEPTH_C);
    assign gnt_s  = req_s & tcdm_gnt_i[k];
    // Responses with nothing outstanding, or outside RUN, are dropped.
    assign push_s = run_s & tcdm_r_valid_i[k] & (outst_q != {CNT_W{1'b0}});
    assign pop_s  = (cnt_q != {CNT_W{1'b0}}) & rd_ready_i[k];

    assign tcdm_req_o[k]                    = req_s;
    assign tcdm_wen_o[k]                    = 1'b1;
    assign tcdm_add_o[k*ADDR_W +: ADDR_W]   = addr_q;
    assign tcdm_data_o[k*DATA_W +: DATA_W]  = {DATA_W{1'b0}};
    assign rd_valid_o[k]                    = (cnt_q != {CNT_W{1'b0}});
    assign rd_data_o[k*DATA_W +: DATA_W]    = mem_q[rptr_q];
    assign rd_done_s[k]                     = (popped_q == len_q);

    // Read channel counters, address accumulator and FIFO pointers
    always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      issued_d = issued_q;
      popped_d = popped_q;
      outst_d  = outst_q;
      cnt_d    = cnt_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      if (launch_s) begin
        addr_d   = base_addr_i[k*ADDR_W +: ADDR_W];
        stride_d = stride_i[k*ADDR_W +: ADDR_W];
        issued_d = {LEN_W{1'b0}};
        popped_d = {LEN_W{1'b0}};
        outst_d  = {CNT_W{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
        wptr_d   = {PTR_W{1'b0}};
        rptr_d   = {PTR_W{1'b0}};
      end else begin
        addr_d   = gnt_s ? (addr_q + stride_q) : addr_q;
        issued_d = issued_q + LEN_W'(gnt_s);
        popped_d = popped_q + LEN_W'(pop_s);
        outst_d  = outst_q + CNT_W'(gnt_s) - CNT_W'(push_s);
        cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
        wptr_d   = wptr_q + PTR_W'(push_s);
        rptr_d   = rptr_q + PTR_W'(pop_s);
      end
    end

    // Read channel state registers
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        addr_q   <= {ADDR_W{1'b0}};
        stride_q <= {ADDR_W{1'b0}};
        issued_q <= {LEN_W{1'b0}};
        popped_q <= {LEN_W{1'b0}};
        outst_q  <= {CNT_W{1'b0}};
        cnt_q    <= {CNT_W{1'b0}};
        wptr_q   <= {PTR_W{1'b0}};
        rptr_q   <= {PTR_W{1'b0}};
      end else begin
        addr_q   <= addr_d;
        stride_q <= stride_d;
        issued_q <= issued_d;
        popped_q <= popped_d;
        outst_q  <= outst_d;
        cnt_q    <= cnt_d;
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
      end
    end

    // Response FIFO storage; contents are qualified by cnt_q, so no reset
    always_ff @(posedge clk_i) begin
      if (push_s) begin
        mem_q[wptr_q] <= tcdm_r_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------- write side
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_stride_q, wr_stride_d;
  logic [LEN_W-1:0]  written_q, written_d;
  logic              wr_req_s, wr_hs_s;

  assign wr_req_s = run_s && (written_q < len_q) && wr_valid_i;
  assign wr_hs_s  = wr_req_s & tcdm_gnt_i[NUM_RD];

  assign tcdm_req_o[NUM_RD]                   = wr_req_s;
  assign tcdm_wen_o[NUM_RD]                   = 1'b0;
  assign tcdm_add_o[NUM_RD*ADDR_W +: ADDR_W]  = wr_addr_q;
  assign tcdm_data_o[NUM_RD*DATA_W +: DATA_W] = wr_data_i;
  assign wr_ready_o                           = wr_hs_s;

  assign all_done_s = (&rd_done_s) && (written_q == len_q);

  // Write channel address accumulator and word counter
  always_comb begin
    wr_addr_d   = wr_addr_q;
    wr_stride_d = wr_stride_q;
    written_d   = written_q;
    if (launch_s) begin
      wr_addr_d   = base_addr_i[NUM_RD*ADDR_W +: ADDR_W];
      wr_stride_d = stride_i[NUM_RD*ADDR_W +: ADDR_W];
      written_d   = {LEN_W{1'b0}};
    end else begin
      wr_addr_d = wr_hs_s ? (wr_addr_q + wr_stride_q) : wr_addr_q;
      written_d = written_q + LEN_W'(wr_hs_s);
    end
  end

  // Write channel state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_stride_q <= {ADDR_W{1'b0}};
      written_q   <= {LEN_W{1'b0}};
    end else begin
      wr_addr_q   <= wr_addr_d;
      wr_stride_q <= wr_stride_d;
      written_q   <= written_d;
    end
  end

endmodule

// File: tb/tb_snax_mac_stream_gen.sv
`timescale 1ns/1ps
module tb_snax_mac_stream_gen;
  localparam int NUM_RD = 3, DATA_W = 32, ADDR_W = 32, FIFO_DEPTH = 4, LEN_W = 16;
  localparam int NCH = NUM_RD + 1;
  localparam int W   = NUM_RD;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    start_i;
  logic [LEN_W-1:0]        len_i;
  logic [NCH*ADDR_W-1:0]   base_addr_i, stride_i;
  logic                    busy_o, done_o;
  logic [NCH-1:0]          tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [NCH*ADDR_W-1:0]   tcdm_add_o;
  logic [NCH*DATA_W/8-1:0] tcdm_be_o;
  logic [NCH*DATA_W-1:0]   tcdm_data_o, tcdm_r_data_i;
  logic [NUM_RD-1:0]       rd_valid_o, rd_ready_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic                    wr_valid_i, wr_ready_o;
  logic [DATA_W-1:0]       wr_data_i;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_q [NUM_RD][$];

  always #5 clk_i = ~clk_i;

  snax_mac_stream_gen #(
    .NUM_RD(NUM_RD), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i)
  );

  // Memory contents seen by the bench's TCDM responder.
  function automatic logic [DATA_W-1:0] mem_word(input int k, input logic [ADDR_W-1:0] a);
    return a ^ (32'h5A00_0000 + (32'(k) << 20));
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; base_addr_i = '0; stride_i = '0;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
    rd_ready_i = '0; wr_valid_i = 1'b0; wr_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if ({busy_o, done_o, tcdm_req_o, rd_valid_o, wr_ready_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b req=%b rd_valid=%b wr_ready=%b want all 0",
               busy_o, done_o, tcdm_req_o, rd_valid_o, wr_ready_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  // Runs one job with a 1-cycle-latency TCDM responder and scoreboards
  // every address, read word, written word and the done/busy handshake.
  task automatic drive_job(input string tag, input logic [LEN_W-1:0] len,
                           input logic [ADDR_W-1:0] base0, input logic [ADDR_W-1:0] base_step,
                           input logic [ADDR_W-1:0] stride, input int gnt_pct,
                           input int hold0, input int budget);
    logic [ADDR_W-1:0] ea [NCH];
    logic [ADDR_W-1:0] pa [NCH];
    logic              pr [NCH];
    int                ng [NCH];
    logic              pv [NUM_RD];
    logic [DATA_W-1:0] pd [NUM_RD];
    int                npop [NUM_RD];
    logic [DATA_W-1:0] wnext, got, want;
    logic [ADDR_W-1:0] a;
    bit                fin;
    int                dones;
    fin = 1'b0; dones = 0; wnext = 32'd1;
    for (int c = 0; c < NCH; c++) begin
      ea[c] = base0 + ADDR_W'(c) * base_step;
      base_addr_i[c*ADDR_W +: ADDR_W] = ea[c];
      stride_i[c*ADDR_W +: ADDR_W]    = stride;
      pr[c] = 1'b0; pa[c] = '0; ng[c] = 0;
    end
    for (int k = 0; k < NUM_RD; k++) begin
      exp_q[k].delete(); pv[k] = 1'b0; pd[k] = '0; npop[k] = 0;
    end
    @(posedge clk_i); #1;
    start_i = 1'b1; len_i = len; tcdm_gnt_i = '0; tcdm_r_valid_i = '0;
    wr_valid_i = 1'b1; wr_data_i = wnext;
    rd_ready_i = '1;
    rd_ready_i[0] = (hold0 == 0);
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        tcdm_r_valid_i[k] = pv[k];
        tcdm_r_data_i[k*DATA_W +: DATA_W] = pd[k];
      end
      for (int c = 0; c < NCH; c++) tcdm_gnt_i[c] = ($urandom_range(99) < gnt_pct);
      rd_ready_i[0] = (cyc >= hold0);
      wr_data_i = wnext;
      @(negedge clk_i);
      for (int c = 0; c < NCH; c++) begin
        a = tcdm_add_o[c*ADDR_W +: ADDR_W];
        if (pr[c]) begin
          vectors++;
          if (!(tcdm_req_o[c] === 1'b1 && a === pa[c])) begin
            miscompares++;
            $display("FAIL %s stable ch%0d: req=%b addr=%h want req=1 addr=%h", tag, c, tcdm_req_o[c], a, pa[c]);
          end
        end
        if (tcdm_req_o[c]) begin
          vectors++;
          if (tcdm_wen_o[c] !== (c < NUM_RD)) begin
            miscompares++;
            $display("FAIL %s wen ch%0d: got %b want %b", tag, c, tcdm_wen_o[c], (c < NUM_RD));
          end
        end
        if (tcdm_req_o[c] && tcdm_gnt_i[c]) begin
          vectors++;
          if (a !== ea[c]) begin
            miscompares++;
            $display("FAIL %s addr ch%0d #%0d: got %h want %h", tag, c, ng[c], a, ea[c]);
          end
          if (c < NUM_RD) begin
            exp_q[c].push_back(mem_word(c, ea[c]));
          end else begin
            vectors++;
            if (tcdm_data_o[W*DATA_W +: DATA_W] !== wnext || wr_ready_o !== 1'b1) begin
              miscompares++;
              $display("FAIL %s wdata #%0d: got %h ready=%b want %h ready=1", tag, ng[c],
                       tcdm_data_o[W*DATA_W +: DATA_W], wr_ready_o, wnext);
            end
            wnext = wnext + 32'd1;
          end
          ea[c] = ea[c] + stride;
          ng[c]++;
        end else if (c == W) begin
          vectors++;
          if (wr_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wr_ready: got %b want 0", tag, wr_ready_o);
          end
        end
        if (c < NUM_RD) begin
          pv[c] = tcdm_req_o[c] && tcdm_gnt_i[c];
          pd[c] = mem_word(c, a);
        end
        pr[c] = tcdm_req_o[c] && !tcdm_gnt_i[c];
        pa[c] = a;
      end
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_valid_o[k] && rd_ready_i[k]) begin
          vectors++;
          got = rd_data_o[k*DATA_W +: DATA_W];
          if (exp_q[k].size() == 0) begin
            miscompares++;
            $display("FAIL %s rd%0d unexpected word: got %h want none", tag, k, got);
          end else begin
            want = exp_q[k].pop_front();
            if (got !== want) begin
              miscompares++;
              $display("FAIL %s rd%0d word #%0d: got %h want %h", tag, k, npop[k], got, want);
            end
          end
          npop[k]++;
        end
      end
      if (hold0 > 0 && cyc == hold0 - 1) begin
        vectors++;
        if (ng[0] != FIFO_DEPTH || tcdm_req_o[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL %s credit: grants=%0d req=%b want grants=%0d req=0", tag, ng[0], tcdm_req_o[0], FIFO_DEPTH);
        end
      end
      if (done_o) begin
        dones++; fin = 1'b1;
        vectors++;
        if (npop[0] != int'(len) || npop[NUM_RD-1] != int'(len) || ng[W] != int'(len) ||
            busy_o !== 1'b1 || tcdm_be_o !== '1 || tcdm_data_o[0 +: DATA_W] !== '0) begin
          miscompares++;
          $display("FAIL %s done: pops=%0d/%0d writes=%0d busy=%b be=%h want %0d busy=1 be=all1",
                   tag, npop[0], npop[NUM_RD-1], ng[W], busy_o, tcdm_be_o, len);
        end
      end
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s timeout: done seen %0d want 1", tag, dones);
    end
    @(posedge clk_i); #1;
    tcdm_r_valid_i = '0; tcdm_gnt_i = '0;
    @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || tcdm_req_o !== '0) begin
      miscompares++;
      $display("FAIL %s end: done=%b busy=%b req=%b want 0/0/0", tag, done_o, busy_o, tcdm_req_o);
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic test_basic();
    drive_job("basic", 16'd4, 32'h100, 32'h100, 32'd4, 100, 0, 200);
  endtask

  task automatic test_backpressure();
    drive_job("backpressure", 16'd8, 32'h2000, 32'h1000, 32'd4, 100, 20, 400);
  endtask

  task automatic test_wrap();
    drive_job("wrap", 16'd4, 32'h8, 32'h0, 32'hFFFF_FFFC, 50, 0, 400);
  endtask

  task automatic test_len_zero();
    int dones;
    dones = 0;
    tcdm_gnt_i = '1; wr_valid_i = 1'b1; rd_ready_i = '1;
    @(posedge clk_i); #1 start_i = 1'b1; len_i = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (i == 1) start_i = 1'b0;
      @(negedge clk_i);
      if (done_o) dones++;
      vectors++;
      if (tcdm_req_o !== '0) begin
        miscompares++;
        $display("FAIL len0 req cycle %0d: got %b want 0", i, tcdm_req_o);
      end
      if (i == 0) begin
        vectors++;
        if (busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL len0 busy: got %b want 1", busy_o);
        end
      end
    end
    vectors++;
    if (dones != 1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL len0 done: pulses=%0d busy=%b want 1 pulse busy=0", dones, busy_o);
    end
    tcdm_gnt_i = '0; wr_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g;
    g = 0;
    base_addr_i = '0; stride_i = '0;
    base_addr_i[0 +: ADDR_W] = 32'h1000; stride_i[0 +: ADDR_W] = 32'd4;
    wr_valid_i = 1'b0; rd_ready_i = '0; tcdm_r_valid_i = '0;
    @(posedge clk_i); #1 start_i = 1'b1; len_i = 16'd8; tcdm_gnt_i = 4'b0001;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (int i = 0; i < 10 && g < 3; i++) begin
      @(negedge clk_i);
      if (tcdm_req_o[0] && tcdm_gnt_i[0]) g++;
      if (g == 3) tcdm_gnt_i = '0;
      else @(posedge clk_i);
    end
    vectors++;
    if (g != 3) begin
      miscompares++;
      $display("FAIL rst_mid grants: got %0d want 3", g);
    end
    @(posedge clk_i); #1 tcdm_r_valid_i[0] = 1'b1; tcdm_r_data_i[0 +: DATA_W] = 32'hDEAD_BEEF;
    @(posedge clk_i); #1 tcdm_r_valid_i[0] = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (rd_valid_o[0] !== 1'b1 || rd_data_o[0 +: DATA_W] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rst_mid push: valid=%b data=%h want 1 deadbeef", rd_valid_o[0], rd_data_o[0 +: DATA_W]);
    end
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    tcdm_r_valid_i[0] = 1'b1; tcdm_gnt_i = '1; wr_valid_i = 1'b1; rd_ready_i = '1;
    @(negedge clk_i);
    vectors++;
    if ({busy_o, done_o, tcdm_req_o, rd_valid_o, wr_ready_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid state: busy=%b done=%b req=%b rd_valid=%b wr_ready=%b want all 0",
               busy_o, done_o, tcdm_req_o, rd_valid_o, wr_ready_o);
    end
    @(posedge clk_i); #1 tcdm_r_valid_i = '0; tcdm_gnt_i = '0; wr_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (rd_valid_o !== '0) begin
      miscompares++;
      $display("FAIL rst_mid late rvalid: rd_valid=%b want 0", rd_valid_o);
    end
    drive_job("post_reset", 16'd2, 32'h3000, 32'h40, 32'd8, 100, 0, 200);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
